// File: rtl/reorder_buffer.sv
// reorder_buffer: circular in-order reorder buffer downstream of dispatch.
//
// Allocates one entry per dispatched instruction at the tail, marks entries
// done from three completion ports, and retires at most one done entry per
// cycle from the head. A branch mispredict discards every entry younger than
// the branch in one cycle.
//
// Ports:
//   clk, reset             - clock, synchronous active-high reset
//   rob_we_in, rob_pd_new_in, rob_pd_old_in, rob_pc_in
//                          - allocate request and entry payload from dispatch
//   rob_tag_out            - tag the next allocation receives (current tail)
//   rob_full_out           - count == DEPTH
//   cmpl_valid_N, cmpl_tag_N (N = 0..2)
//                          - completion strobes and tags
//   commit_valid_out, commit_pd_new_out, commit_pd_old_out, commit_pc_out
//                          - head entry retiring this cycle (zero when idle)
//   commit_free_valid_out  - retiring pd_old goes back to the free list
//   mispredict, mispredict_tag
//                          - flush everything younger than mispredict_tag
//   empty_out              - count == 0

// One ROB slot: valid/done state and the payload captured at allocation.
module rob_entry #(
  parameter int PREG_W = 7
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              alloc,
  input  logic              cmpl,
  input  logic              clear,
  input  logic [PREG_W-1:0] pd_new_in,
  input  logic [PREG_W-1:0] pd_old_in,
  input  logic [31:0]       pc_in,
  output logic              valid,
  output logic              done,
  output logic [PREG_W-1:0] pd_new,
  output logic [PREG_W-1:0] pd_old,
  output logic [31:0]       pc
);
  // alloc and clear never target the same slot in one cycle: alloc is blocked
  // during a flush, and alloc at head while committing only happens when full,
  // where alloc is dropped. clear beats cmpl so flushed/retired tags stay clean.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid  <= 1'b0;
      done   <= 1'b0;
      pd_new <= '0;
      pd_old <= '0;
      pc     <= '0;
    end else if (alloc) begin
      valid  <= 1'b1;
      done   <= 1'b0;
      pd_new <= pd_new_in;
      pd_old <= pd_old_in;
      pc     <= pc_in;
    end else if (clear) begin
      valid <= 1'b0;
      done  <= 1'b0;
    end else if (cmpl && valid) begin
      done <= 1'b1;
    end
  end
endmodule

module reorder_buffer #(
  parameter int DEPTH  = 32,
  parameter int TAG_W  = 5,
  parameter int PREG_W = 7
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rob_we_in,
  input  logic [PREG_W-1:0] rob_pd_new_in,
  input  logic [PREG_W-1:0] rob_pd_old_in,
  input  logic [31:0]       rob_pc_in,
  output logic [TAG_W-1:0]  rob_tag_out,
  output logic              rob_full_out,
  input  logic              cmpl_valid_0,
  input  logic [TAG_W-1:0]  cmpl_tag_0,
  input  logic              cmpl_valid_1,
  input  logic [TAG_W-1:0]  cmpl_tag_1,
  input  logic              cmpl_valid_2,
  input  logic [TAG_W-1:0]  cmpl_tag_2,
  output logic              commit_valid_out,
  output logic [PREG_W-1:0] commit_pd_new_out,
  output logic [PREG_W-1:0] commit_pd_old_out,
  output logic              commit_free_valid_out,
  output logic [31:0]       commit_pc_out,
  input  logic              mispredict,
  input  logic [TAG_W-1:0]  mispredict_tag,
  output logic              empty_out
);
  localparam logic [TAG_W-1:0] TAG_ONE = TAG_W'(1);
  localparam logic [TAG_W:0]   CNT_ONE = (TAG_W+1)'(1);
  localparam logic [TAG_W:0]   CNT_MAX = (TAG_W+1)'(DEPTH);

  logic [TAG_W-1:0]  head, tail, head_next, tail_next;
  logic [TAG_W:0]    count, count_next;
  logic [TAG_W-1:0]  flush_lim, br_dist;
  logic              alloc, commit;

  logic [DEPTH-1:0]  valid, done, alloc_sel, cmpl_hit, clear;
  logic [PREG_W-1:0] pd_new_q [DEPTH];
  logic [PREG_W-1:0] pd_old_q [DEPTH];
  logic [31:0]       pc_q     [DEPTH];

  assign rob_full_out = (count == CNT_MAX);
  assign empty_out    = (count == '0);
  assign rob_tag_out  = tail;

  // Full is the pre-commit flag, so a full ROB never reuses the retiring slot
  // in the same cycle.
  assign alloc  = rob_we_in && !rob_full_out && !mispredict;
  assign commit = valid[head] && done[head];

  assign commit_valid_out      = commit;
  assign commit_pd_new_out     = commit ? pd_new_q[head] : '0;
  assign commit_pd_old_out     = commit ? pd_old_q[head] : '0;
  assign commit_pc_out         = commit ? pc_q[head]     : '0;
  assign commit_free_valid_out = commit && (pd_old_q[head] != '0);

  // Younger entries sit at distance 1..flush_lim past the branch. When the
  // branch is the youngest entry flush_lim is 0 and nothing is flushed, which
  // also keeps a full ROB full.
  assign flush_lim = tail - mispredict_tag - TAG_ONE;

  always_comb begin
    alloc_sel = '0;
    cmpl_hit  = '0;
    clear     = '0;
    for (int i = 0; i < DEPTH; i++) begin
      alloc_sel[i] = alloc && (tail == TAG_W'(i));
      cmpl_hit[i]  = (cmpl_valid_0 && (cmpl_tag_0 == TAG_W'(i))) ||
                     (cmpl_valid_1 && (cmpl_tag_1 == TAG_W'(i))) ||
                     (cmpl_valid_2 && (cmpl_tag_2 == TAG_W'(i)));
      clear[i]     = (commit && (head == TAG_W'(i))) ||
                     (mispredict &&
                      ((TAG_W'(i) - mispredict_tag) != '0) &&
                      ((TAG_W'(i) - mispredict_tag) <= flush_lim));
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_entry
    rob_entry #(.PREG_W(PREG_W)) u_entry (
      .clk       (clk),
      .reset     (reset),
      .alloc     (alloc_sel[g]),
      .cmpl      (cmpl_hit[g]),
      .clear     (clear[g]),
      .pd_new_in (rob_pd_new_in),
      .pd_old_in (rob_pd_old_in),
      .pc_in     (rob_pc_in),
      .valid     (valid[g]),
      .done      (done[g]),
      .pd_new    (pd_new_q[g]),
      .pd_old    (pd_old_q[g]),
      .pc        (pc_q[g])
    );
  end

  always_comb begin
    head_next = commit ? head + TAG_ONE : head;
    br_dist   = mispredict_tag - head_next;
    if (mispredict) begin
      tail_next = mispredict_tag + TAG_ONE;
      // Branch retiring this cycle leaves nothing behind it.
      if (commit && (head == mispredict_tag))
        count_next = '0;
      else
        count_next = {1'b0, br_dist} + CNT_ONE;
    end else begin
      tail_next  = alloc ? tail + TAG_ONE : tail;
      count_next = count + {{TAG_W{1'b0}}, alloc} - {{TAG_W{1'b0}}, commit};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head_next;
      tail  <= tail_next;
      count <= count_next;
    end
  end
endmodule

// File: tb/tb_reorder_buffer.sv
// Scoreboard bench for reorder_buffer: allocations push the expected retire
// record, flushes/reset trim the queue, and a negedge monitor pops and
// compares every commit.
module tb_reorder_buffer;
  logic        clk = 1'b0;
  logic        reset;
  logic        rob_we_in;
  logic [6:0]  rob_pd_new_in, rob_pd_old_in;
  logic [31:0] rob_pc_in;
  logic [4:0]  rob_tag_out;
  logic        rob_full_out;
  logic        cmpl_valid_0, cmpl_valid_1, cmpl_valid_2;
  logic [4:0]  cmpl_tag_0, cmpl_tag_1, cmpl_tag_2;
  logic        commit_valid_out, commit_free_valid_out;
  logic [6:0]  commit_pd_new_out, commit_pd_old_out;
  logic [31:0] commit_pc_out;
  logic        mispredict;
  logic [4:0]  mispredict_tag;
  logic        empty_out;

  reorder_buffer #(.DEPTH(32), .TAG_W(5), .PREG_W(7)) dut (
    .clk(clk), .reset(reset),
    .rob_we_in(rob_we_in), .rob_pd_new_in(rob_pd_new_in),
    .rob_pd_old_in(rob_pd_old_in), .rob_pc_in(rob_pc_in),
    .rob_tag_out(rob_tag_out), .rob_full_out(rob_full_out),
    .cmpl_valid_0(cmpl_valid_0), .cmpl_tag_0(cmpl_tag_0),
    .cmpl_valid_1(cmpl_valid_1), .cmpl_tag_1(cmpl_tag_1),
    .cmpl_valid_2(cmpl_valid_2), .cmpl_tag_2(cmpl_tag_2),
    .commit_valid_out(commit_valid_out), .commit_pd_new_out(commit_pd_new_out),
    .commit_pd_old_out(commit_pd_old_out),
    .commit_free_valid_out(commit_free_valid_out),
    .commit_pc_out(commit_pc_out),
    .mispredict(mispredict), .mispredict_tag(mispredict_tag),
    .empty_out(empty_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [6:0]  pdn;
    logic [6:0]  pdo;
    logic [31:0] pc;
  } ent_t;

  ent_t exp_q[$];
  ent_t mon_e;
  int   checks = 0;
  int   fails  = 0;
  bit   hit;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Commit monitor: every retire must match the oldest outstanding allocation.
  always @(negedge clk) begin
    if (!reset) begin
      if (commit_valid_out) begin
        if (exp_q.size() == 0) begin
          checks++;
          fails++;
          $display("FAIL unexpected_commit: got pc %0h, expected no commit", commit_pc_out);
        end else begin
          mon_e = exp_q.pop_front();
          chk("commit_pd_new", 32'(commit_pd_new_out), 32'(mon_e.pdn));
          chk("commit_pd_old", 32'(commit_pd_old_out), 32'(mon_e.pdo));
          chk("commit_pc", commit_pc_out, mon_e.pc);
          chk("commit_free", 32'(commit_free_valid_out), 32'(mon_e.pdo != 7'd0));
        end
      end else begin
        chk("idle_data", {commit_pd_new_out, commit_pd_old_out, commit_free_valid_out}
                         | commit_pc_out, 32'd0);
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    exp_q.delete();
    cyc();
    cyc();
    reset = 1'b0;
  endtask

  task automatic do_alloc(input logic [6:0] pdn, input logic [6:0] pdo,
                          input logic [31:0] pc, input logic [4:0] exp_tag);
    ent_t e;
    rob_we_in = 1'b1;
    rob_pd_new_in = pdn;
    rob_pd_old_in = pdo;
    rob_pc_in = pc;
    @(negedge clk);
    chk("alloc_tag", 32'(rob_tag_out), 32'(exp_tag));
    e.pdn = pdn; e.pdo = pdo; e.pc = pc;
    exp_q.push_back(e);
    cyc();
    rob_we_in = 1'b0;
  endtask

  task automatic cmpl3(input logic v0, input logic [4:0] t0, input logic v1,
                       input logic [4:0] t1, input logic v2, input logic [4:0] t2);
    cmpl_valid_0 = v0; cmpl_tag_0 = t0;
    cmpl_valid_1 = v1; cmpl_tag_1 = t1;
    cmpl_valid_2 = v2; cmpl_tag_2 = t2;
    cyc();
    cmpl_valid_0 = 1'b0; cmpl_valid_1 = 1'b0; cmpl_valid_2 = 1'b0;
  endtask

  initial begin
    reset = 1'b1; rob_we_in = 1'b0;
    rob_pd_new_in = '0; rob_pd_old_in = '0; rob_pc_in = '0;
    cmpl_valid_0 = 1'b0; cmpl_valid_1 = 1'b0; cmpl_valid_2 = 1'b0;
    cmpl_tag_0 = '0; cmpl_tag_1 = '0; cmpl_tag_2 = '0;
    mispredict = 1'b0; mispredict_tag = '0;

    // Reset state
    do_reset();
    @(negedge clk);
    chk("rst_tag", 32'(rob_tag_out), 32'd0);
    chk("rst_full", 32'(rob_full_out), 32'd0);
    chk("rst_empty", 32'(empty_out), 32'd1);
    chk("rst_commit", 32'(commit_valid_out), 32'd0);
    cyc();

    // Three allocations, out-of-order completion
    do_alloc(7'd33, 7'd1, 32'h100, 5'd0);
    do_alloc(7'd34, 7'd0, 32'h104, 5'd1);
    do_alloc(7'd35, 7'd2, 32'h108, 5'd2);
    @(negedge clk);
    chk("t1_tag", 32'(rob_tag_out), 32'd3);
    chk("t1_empty", 32'(empty_out), 32'd0);
    chk("t1_nocommit", 32'(commit_valid_out), 32'd0);
    cyc();
    cmpl3(1'b1, 5'd1, 1'b0, 5'd0, 1'b0, 5'd0);
    @(negedge clk);
    chk("t1_blocked", 32'(commit_valid_out), 32'd0);
    cyc();
    cmpl3(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0);
    cyc();
    cyc();
    @(negedge clk);
    chk("t1_wait2", 32'(commit_valid_out), 32'd0);
    cyc();
    cmpl3(1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd2);
    cyc();
    @(negedge clk);
    chk("t1_empty_end", 32'(empty_out), 32'd1);
    chk("t1_tag_end", 32'(rob_tag_out), 32'd3);
    chk("t1_drained", 32'(exp_q.size()), 32'd0);
    cyc();

    // Fill to 32, drop while full, then commit-with-alloc-held
    do_reset();
    for (int i = 0; i < 32; i++)
      do_alloc(7'(i + 40), 7'(i), 32'(32'h200 + 4 * i), 5'(i));
    @(negedge clk);
    chk("t2_full", 32'(rob_full_out), 32'd1);
    chk("t2_tag", 32'(rob_tag_out), 32'd0);
    cyc();
    rob_we_in = 1'b1; rob_pd_new_in = 7'd99; rob_pd_old_in = 7'd5; rob_pc_in = 32'h300;
    cyc();
    @(negedge clk);
    chk("t2_drop_full", 32'(rob_full_out), 32'd1);
    chk("t2_drop_tag", 32'(rob_tag_out), 32'd0);
    cyc();
    cmpl3(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0);
    @(negedge clk);
    chk("t2_commit_full", 32'(rob_full_out), 32'd1);
    chk("t2_commit_vld", 32'(commit_valid_out), 32'd1);
    cyc();
    @(negedge clk);
    chk("t2_reuse_full", 32'(rob_full_out), 32'd0);
    chk("t2_reuse_tag", 32'(rob_tag_out), 32'd0);
    begin
      ent_t e;
      e.pdn = 7'd99; e.pdo = 7'd5; e.pc = 32'h300;
      exp_q.push_back(e);
    end
    cyc();
    rob_we_in = 1'b0;
    @(negedge clk);
    chk("t2_refull", 32'(rob_full_out), 32'd1);
    chk("t2_retag", 32'(rob_tag_out), 32'd1);
    cyc();

    // Wrapped window 28..5, mispredict at 30 with a stale completion on 2
    do_reset();
    for (int i = 0; i < 28; i++)
      do_alloc(7'(i + 10), 7'(i), 32'(32'h1000 + 4 * i), 5'(i));
    for (int t = 0; t < 28; t += 3)
      cmpl3(1'b1, 5'(t), (t + 1) < 28, 5'(t + 1), (t + 2) < 28, 5'(t + 2));
    hit = 1'b0;
    for (int k = 0; k < 80; k++) begin
      @(negedge clk);
      if (empty_out) begin hit = 1'b1; break; end
    end
    chk("t3_drain_timeout", 32'(hit), 32'd1);
    cyc();
    for (int i = 0; i < 10; i++)
      do_alloc(7'(i + 60), 7'(i + 3), 32'(32'h2000 + 4 * i), 5'(28 + i));
    @(negedge clk);
    chk("t3_pre_tag", 32'(rob_tag_out), 32'd6);
    mispredict = 1'b1; mispredict_tag = 5'd30;
    cmpl_valid_1 = 1'b1; cmpl_tag_1 = 5'd2;
    for (int i = 0; i < 7; i++) void'(exp_q.pop_back());
    cyc();
    mispredict = 1'b0; cmpl_valid_1 = 1'b0;
    @(negedge clk);
    chk("t3_tail", 32'(rob_tag_out), 32'd31);
    chk("t3_empty", 32'(empty_out), 32'd0);
    chk("t3_full", 32'(rob_full_out), 32'd0);
    chk("t3_nocommit", 32'(commit_valid_out), 32'd0);
    cyc();
    cmpl3(1'b1, 5'd28, 1'b1, 5'd29, 1'b1, 5'd30);
    cyc();
    cyc();
    @(negedge clk);
    chk("t3_last_live", 32'(empty_out), 32'd0);
    chk("t3_last_commit", 32'(commit_valid_out), 32'd1);
    cyc();
    @(negedge clk);
    chk("t3_count3_empty", 32'(empty_out), 32'd1);
    chk("t3_end_tag", 32'(rob_tag_out), 32'd31);
    chk("t3_drained", 32'(exp_q.size()), 32'd0);
    cyc();

    // Branch at head commits while its younger entries are flushed
    do_reset();
    for (int i = 0; i < 8; i++)
      do_alloc(7'(i + 20), 7'(i + 1), 32'(32'h400 + 4 * i), 5'(i));
    cmpl3(1'b1, 5'd0, 1'b1, 5'd1, 1'b1, 5'd2);
    cmpl3(1'b1, 5'd3, 1'b1, 5'd4, 1'b0, 5'd0);
    hit = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (commit_valid_out && commit_pc_out == 32'h410) begin hit = 1'b1; break; end
    end
    chk("t4_reach_branch", 32'(hit), 32'd1);
    mispredict = 1'b1; mispredict_tag = 5'd4;
    for (int i = 0; i < 3; i++) void'(exp_q.pop_back());
    @(posedge clk);
    #1;
    mispredict = 1'b0;
    @(negedge clk);
    chk("t4_empty", 32'(empty_out), 32'd1);
    chk("t4_tail", 32'(rob_tag_out), 32'd5);
    chk("t4_nocommit", 32'(commit_valid_out), 32'd0);
    cyc();
    do_alloc(7'd50, 7'd9, 32'h500, 5'd5);
    cmpl3(1'b1, 5'd5, 1'b0, 5'd0, 1'b0, 5'd0);
    cyc();
    @(negedge clk);
    chk("t4_drained", 32'(exp_q.size()), 32'd0);
    chk("t4_empty_end", 32'(empty_out), 32'd1);
    cyc();

    // Reset mid-operation with 20 live entries and completions in flight
    for (int i = 0; i < 20; i++)
      do_alloc(7'(i + 70), 7'(i), 32'(32'h3000 + 4 * i), 5'(6 + i));
    reset = 1'b1; rob_we_in = 1'b1;
    cmpl_valid_0 = 1'b1; cmpl_tag_0 = 5'd6;
    cmpl_valid_1 = 1'b1; cmpl_tag_1 = 5'd7;
    cmpl_valid_2 = 1'b1; cmpl_tag_2 = 5'd8;
    exp_q.delete();
    cyc();
    reset = 1'b0; rob_we_in = 1'b0;
    cmpl_valid_0 = 1'b0; cmpl_valid_1 = 1'b0; cmpl_valid_2 = 1'b0;
    @(negedge clk);
    chk("t5_empty", 32'(empty_out), 32'd1);
    chk("t5_tag", 32'(rob_tag_out), 32'd0);
    chk("t5_nocommit", 32'(commit_valid_out), 32'd0);
    chk("t5_full", 32'(rob_full_out), 32'd0);
    cyc();
    do_alloc(7'd88, 7'd3, 32'h600, 5'd0);
    cmpl3(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0);
    cyc();
    @(negedge clk);
    chk("t5_drained", 32'(exp_q.size()), 32'd0);
    chk("t5_empty_end", 32'(empty_out), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
